udi_evt_capture: RTL and testbench

- Downstream consumer of the spectral-density UDI results.
- Each cycle it receives one committed (not killed) M-stage UDI result: the computed power value plus the threshold-compare bit.
- A crossing-detector FSM turns hit/miss sequences into START/END event records, queued in a small FIFO.
- The FIFO drains to the external system over a valid/ready handshake, intended to feed UDI_fromudi.

---
 rtl/udi_evt_capture_pkg.sv | 20 ++
 rtl/udi_evt_fifo.sv | 68 ++++++
 rtl/udi_evt_capture.sv | 187 ++++++++++++++++++
 tb/tb_udi_evt_capture.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udi_evt_capture_pkg.sv
// Shared definitions for the UDI event-capture block: record-type codes,
// crossing-detector state encoding and the packed record width helper.
package udi_evt_capture_pkg;

  // Record type carried in ev_type
  localparam logic EVT_START = 1'b0;
  localparam logic EVT_END   = 1'b1;

  // Crossing-detector states
  typedef enum logic {
    ST_QUIET = 1'b0,
    ST_ABOVE = 1'b1
  } evt_state_t;

  // Packed record width: type bit + sample index + 32-bit power + length
  function automatic int rec_width(input int idx_w, input int len_w);
    return 1 + idx_w + 32 + len_w;
  endfunction

endpackage

// File: rtl/udi_evt_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with async active-high reset and
// synchronous clear. The head is shown straight from storage while non-empty;
// once empty it holds the last popped word so the consumer side stays quiet.
module udi_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? hold_reg : mem[rd_ptr_reg];

  // Storage write; pointers and count decide what is live
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the last-popped holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        hold_reg   <= mem[rd_ptr_reg];
      end
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/udi_evt_capture.sv
// UDI spectral-density event capture: turns the per-sample threshold-compare
// stream into START/END crossing records and queues them for the consumer.
// Optional build macro UDI_EVT_DEBOUNCE_EN: a crossing closes only after
// DEBOUNCE consecutive misses instead of a single miss.
module udi_evt_capture
  import udi_evt_capture_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IDX_W    = 16,
  parameter int LEN_W    = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             UDI_gclk,
  input  logic             UDI_greset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_hit,
  input  logic [31:0]      in_power,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ev_type,
  output logic [IDX_W-1:0] ev_index,
  output logic [31:0]      ev_value,
  output logic [LEN_W-1:0] ev_len,
  output logic             above,
  output logic             ovf,
  output logic [7:0]       ovf_cnt
);

  localparam int REC_W = rec_width(IDX_W, LEN_W);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("udi_evt_capture: DEPTH must be a power of two >= 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("udi_evt_capture: DEBOUNCE must be >= 1");
  end

  typedef struct packed {
    logic             typ;
    logic [IDX_W-1:0] index;
    logic [31:0]      value;
    logic [LEN_W-1:0] len;
  } rec_t;

  evt_state_t       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      peak_reg;
  logic [LEN_W-1:0] len_reg;
`ifdef UDI_EVT_DEBOUNCE_EN
  localparam int MISS_W = $clog2(DEBOUNCE + 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(DEBOUNCE - 1);
  logic [MISS_W-1:0] miss_reg;
  logic              end_now;
  assign end_now = (miss_reg == MISS_LAST);
`else
  logic              end_now;
  assign end_now = 1'b1;
`endif

  logic             push;
  rec_t             push_rec;
  rec_t             head_rec;
  logic [REC_W-1:0] head_bits;
  logic             pop;
  logic             full;
  logic             empty;

  assign ev_valid = !empty;
  assign pop      = !empty && ev_ready;
  assign head_rec = head_bits;
  assign ev_type  = head_rec.typ;
  assign ev_index = head_rec.index;
  assign ev_value = head_rec.value;
  assign ev_len   = head_rec.len;
  assign above    = (state_reg == ST_ABOVE);

  // Record generation for the current sample; clear suppresses any push
  always_comb begin
    push           = 1'b0;
    push_rec       = '0;
    push_rec.index = idx_reg;
    if (in_valid && !clr) begin
      case (state_reg)
        ST_QUIET: begin
          if (in_hit) begin
            push           = 1'b1;
            push_rec.typ   = EVT_START;
            push_rec.value = in_power;
          end
        end
        ST_ABOVE: begin
          if (!in_hit && end_now) begin
            push           = 1'b1;
            push_rec.typ   = EVT_END;
            push_rec.value = peak_reg;
            push_rec.len   = len_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Crossing detector, sample index and overflow accounting
  always_ff @(posedge UDI_gclk or posedge UDI_greset) begin
    if (UDI_greset) begin
      state_reg <= ST_QUIET;
      idx_reg   <= '0;
      peak_reg  <= '0;
      len_reg   <= '0;
      ovf       <= 1'b0;
      ovf_cnt   <= '0;
`ifdef UDI_EVT_DEBOUNCE_EN
      miss_reg  <= '0;
`endif
    end else if (clr) begin
      state_reg <= ST_QUIET;
      idx_reg   <= '0;
      peak_reg  <= '0;
      len_reg   <= '0;
      ovf       <= 1'b0;
      ovf_cnt   <= '0;
`ifdef UDI_EVT_DEBOUNCE_EN
      miss_reg  <= '0;
`endif
    end else begin
      if (in_valid) begin
        idx_reg <= idx_reg + 1'b1;
        case (state_reg)
          ST_QUIET: begin
            if (in_hit) begin
              state_reg <= ST_ABOVE;
              peak_reg  <= in_power;
              len_reg   <= LEN_W'(1);
`ifdef UDI_EVT_DEBOUNCE_EN
              miss_reg  <= '0;
`endif
            end
          end
          ST_ABOVE: begin
            if (in_hit) begin
              peak_reg <= (in_power > peak_reg) ? in_power : peak_reg;
              if (len_reg != '1) begin
                len_reg <= len_reg + 1'b1;
              end
`ifdef UDI_EVT_DEBOUNCE_EN
              miss_reg <= '0;
`endif
            end else if (end_now) begin
              state_reg <= ST_QUIET;
`ifdef UDI_EVT_DEBOUNCE_EN
              miss_reg  <= '0;
            end else begin
              miss_reg  <= miss_reg + 1'b1;
`endif
            end
          end
          default: state_reg <= ST_QUIET;
        endcase
      end
      // The FSM moves on regardless; only the record is lost
      if (push && full && !pop) begin
        ovf <= 1'b1;
        if (ovf_cnt != 8'hFF) begin
          ovf_cnt <= ovf_cnt + 1'b1;
        end
      end
    end
  end

  udi_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (UDI_gclk),
    .rst       (UDI_greset),
    .clr       (clr),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_bits),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_udi_evt_capture.sv
// Testbench for udi_evt_capture: a queue-based behavioural model checked every
// cycle, plus directed sequences with hand-computed records.
module tb_udi_evt_capture;

`ifdef UDI_EVT_DEBOUNCE_EN
  localparam int DB = 3;
`else
  localparam int DB = 1;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hit = 1'b0;
  logic [31:0] in_power = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic        ev_type;
  logic [15:0] ev_index;
  logic [31:0] ev_value;
  logic [15:0] ev_len;
  logic        above;
  logic        ovf;
  logic [7:0]  ovf_cnt;

  always #5 clk = ~clk;

  udi_evt_capture #(
    .DEPTH(DEPTH), .IDX_W(16), .LEN_W(16), .DEBOUNCE(3)
  ) dut (
    .UDI_gclk(clk), .UDI_greset(rst), .clr(clr),
    .in_valid(in_valid), .in_hit(in_hit), .in_power(in_power),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_index(ev_index), .ev_value(ev_value), .ev_len(ev_len),
    .above(above), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  typedef struct {
    bit        typ;
    bit [15:0] idx;
    bit [31:0] val;
    bit [15:0] len;
  } rec_t;

  int checks = 0;
  int errs   = 0;

  // Model state: an open crossing is just "where it started, its peak, how
  // many hits, how many trailing misses"; the queue is the FIFO contents.
  rec_t      mq[$];
  rec_t      m_last;
  bit        m_run;
  bit [15:0] m_idx;
  bit [31:0] m_peak;
  bit [15:0] m_hits;
  int        m_miss;
  bit        m_ovf;
  bit [7:0]  m_ocnt;
  rec_t      got[$];

  task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got_v, exp_v);
    end
  endtask

  // Model update on the same edge the DUT samples
  always @(posedge clk) begin : model
    rec_t r;
    bit   do_pop;
    bit   do_push;
    if (rst || clr) begin
      mq.delete();
      m_last = '{0, 0, 0, 0};
      m_run = 0; m_idx = 0; m_peak = 0; m_hits = 0; m_miss = 0;
      m_ovf = 0; m_ocnt = 0;
    end else begin
      do_pop  = (mq.size() > 0) && (ev_ready === 1'b1);
      do_push = 0;
      r = '{0, 0, 0, 0};
      if (in_valid) begin
        if (!m_run) begin
          if (in_hit) begin
            r = '{0, m_idx, in_power, 0};
            do_push = 1;
            m_run = 1; m_peak = in_power; m_hits = 1; m_miss = 0;
          end
        end else if (in_hit) begin
          if (in_power > m_peak) m_peak = in_power;
          if (m_hits != 16'hFFFF) m_hits++;
          m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss >= DB) begin
            r = '{1, m_idx, m_peak, m_hits};
            do_push = 1;
            m_run = 0;
          end
        end
        m_idx++;
      end
      if (do_pop) m_last = mq.pop_front();
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
          m_ovf = 1;
          if (m_ocnt != 8'hFF) m_ocnt++;
        end
      end
    end
  end

  // Log of records actually handed to the consumer
  always @(posedge clk) begin
    if (!rst && !clr && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      got.push_back('{ev_type, ev_index, ev_value, ev_len});
      $display("pop type=%0d idx=%0d value=%0d len=%0d", ev_type, ev_index, ev_value, ev_len);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    rec_t e;
    if (!rst) begin
      e = (mq.size() > 0) ? mq[0] : m_last;
      chk("above", above, m_run);
      chk("ovf", ovf, m_ovf);
      chk("ovf_cnt", ovf_cnt, m_ocnt);
      chk("ev_valid", ev_valid, mq.size() > 0);
      chk("ev_type", ev_type, e.typ);
      chk("ev_index", ev_index, e.idx);
      chk("ev_value", ev_value, e.val);
      chk("ev_len", ev_len, e.len);
    end
  end

  task automatic step(input bit v, input bit h, input int unsigned p);
    in_valid = v; in_hit = h; in_power = p;
    @(posedge clk); #1;
    in_valid = 0; in_hit = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    got.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_above", above, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_ev_index", ev_index, 0);
    @(posedge clk); #1;
    rst = 0;

    // Ten misses, then a START at index 10
    ev_ready = 1;
    repeat (10) step(1, 0, 5);
    step(1, 1, 77);
    @(negedge clk);
    chk("t1_start_valid", ev_valid, 1);
    chk("t1_start_idx", ev_index, 10);
    chk("t1_start_type", ev_type, 0);
    repeat (DB) step(1, 0, 0);
    idle(3);

    // Basic crossing: miss, 100, 300, 200, miss
    do_clr();
    step(1, 0, 9);
    step(1, 1, 100);
    @(negedge clk);
    chk("t2_start_vis", ev_valid, 1);
    chk("t2_start_idx", ev_index, 1);
    chk("t2_start_val", ev_value, 100);
    chk("t2_start_len", ev_len, 0);
    step(1, 1, 300);
    step(1, 1, 200);
    chk("t2_above", above, 1);
    step(1, 0, 50);
    idle(4);
`ifndef UDI_EVT_DEBOUNCE_EN
    chk("t2_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t2_end_type", got[1].typ, 1);
      chk("t2_end_idx", got[1].idx, 4);
      chk("t2_end_val", got[1].val, 300);
      chk("t2_end_len", got[1].len, 3);
    end
`endif

    // Stalled consumer, three crossings into a 4-deep FIFO
    do_clr();
    ev_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1000 + k);
      step(1, 0, 1);
    end
    idle(3);
`ifndef UDI_EVT_DEBOUNCE_EN
    chk("t3_ovf", ovf, 1);
    chk("t3_ovf_cnt", ovf_cnt, 2);
    chk("t3_head_idx", ev_index, 0);
`endif
    ev_ready = 1;
    idle(8);
`ifndef UDI_EVT_DEBOUNCE_EN
    chk("t3_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) begin
      chk("t3_order_idx", got[i].idx, i);
      chk("t3_order_type", got[i].typ, i % 2);
    end
`endif

    // Full FIFO with simultaneous push and pop
    do_clr();
    ev_ready = 0;
    step(1, 1, 10); step(1, 0, 0);
    step(1, 1, 20); step(1, 0, 0);
    idle(2);
    ev_ready = 1;
    step(1, 1, 30);
    step(1, 0, 0);
    idle(8);
`ifndef UDI_EVT_DEBOUNCE_EN
    chk("t4_ovf", ovf, 0);
    chk("t4_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("t4_order_idx", got[i].idx, i);
    if (got.size() == 6) chk("t4_pushed_val", got[4].val, 30);
`endif

    // Index wrap
    do_clr();
    ev_ready = 1;
    repeat (65535) step(1, 0, 0);
    step(1, 1, 555);
    repeat (3) step(1, 0, 0);
    idle(3);
    chk("t5_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_start_idx", got[0].idx, 65535);
      chk("t5_end_idx", got[1].idx, DB - 1);
      chk("t5_end_len", got[1].len, 1);
      chk("t5_end_val", got[1].val, 555);
    end

    // hit, miss, miss, hit, miss, miss, miss
    do_clr();
    step(1, 1, 10);
    step(1, 0, 0); step(1, 0, 0);
    step(1, 1, 40);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    idle(4);
`ifdef UDI_EVT_DEBOUNCE_EN
    chk("t6_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t6_end_idx", got[1].idx, 6);
      chk("t6_end_len", got[1].len, 2);
      chk("t6_end_val", got[1].val, 40);
    end
`else
    chk("t6_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t6_end1_idx", got[1].idx, 1);
      chk("t6_start2_idx", got[2].idx, 3);
      chk("t6_end2_len", got[3].len, 1);
    end
`endif

    // Clear in the middle of a crossing
    do_clr();
    ev_ready = 0;
    step(1, 1, 99);
    @(negedge clk);
    chk("t7_above_pre", above, 1);
    chk("t7_valid_pre", ev_valid, 1);
    do_clr();
    @(negedge clk);
    chk("t7_above_post", above, 0);
    chk("t7_valid_post", ev_valid, 0);
    chk("t7_index_post", ev_index, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
